// File: rtl/mdc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdc_pkg
// Purpose  : Shared definitions for the coffee-machine dispenser: command
//            codes, dispenser state encoding and the actuator exclusion helper.
// Ports    : none (package)
// Options  : MDC_CUP_SENSE_EN enables the WAIT_CUP state in the dispenser
// Revision : 1.0 - initial release
// ============================================================================
package mdc_pkg;

    // Command codes driven by maquina_de_cafe.out
    localparam logic [2:0] c_cmd_none      = 3'b000;
    localparam logic [2:0] c_cmd_cafe      = 3'b001;
    localparam logic [2:0] c_cmd_te        = 3'b010;
    localparam logic [2:0] c_cmd_err_agua  = 3'b011;
    localparam logic [2:0] c_cmd_err_cafe  = 3'b100;
    localparam logic [2:0] c_cmd_cambio    = 3'b101;
    localparam logic [2:0] c_cmd_rsvd      = 3'b110;
    localparam logic [2:0] c_cmd_devolver  = 3'b111;

    // Dispenser state encoding
    localparam int         c_st_w          = 3;
    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_heat       = 3'd1;
    localparam logic [2:0] c_st_pour       = 3'd2;
    localparam logic [2:0] c_st_eject      = 3'd3;
    localparam logic [2:0] c_st_fault      = 3'd4;
    localparam logic [2:0] c_st_done       = 3'd5;
    localparam logic [2:0] c_st_wait_cup   = 3'd6;

    // At most one member of an exclusive actuator pair may be on
    localparam int         c_excl_max_on   = 1;

    function automatic int mdc_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic mdc_excl_ok(input logic a, input logic b);
        return (int'(a) + int'(b)) <= c_excl_max_on;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdc_temporizador.sv
`default_nettype none
// ============================================================================
// Module   : mdc_temporizador
// Purpose  : Loadable down-counter shared by every timed dispenser phase.
//            Stops at zero (never wraps); zero flag is combinational.
// Ports    : clk, rst (sync, active-low), load, value, en -> zero
//            count (only with MDC_CUP_SENSE_EN, used to save pour progress)
// Options  : MDC_CUP_SENSE_EN
// Revision : 1.0 - initial release
// ============================================================================
module mdc_temporizador #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             en,
`ifdef MDC_CUP_SENSE_EN
    output logic [WIDTH-1:0] count,
`endif
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero  = (r_count == '0);
`ifdef MDC_CUP_SENSE_EN
    assign count = r_count;
`endif

endmodule
`default_nettype wire

// File: rtl/mdc_dispensador.sv
`default_nettype none
// ============================================================================
// Module   : mdc_dispensador
// Purpose  : Actuator-side responder for the coffee machine controller. Each
//            newly presented command (after an intervening NONE) runs one timed
//            actuator sequence; busy/done report progress.
// Ports    : clk, rst (sync, active-low), cmd[2:0], cup_ok (optional)
//            -> heater, valve_agua, valve_cafe, valve_te, eject_moneda,
//               eject_cinco, err_led, busy, done (all registered)
// Options  : MDC_CUP_SENSE_EN adds cup_ok and the WAIT_CUP state
// Revision : 1.0 - initial release
// ============================================================================
module mdc_dispensador
    import mdc_pkg::*;
#(
    parameter int HEAT_CYC    = 8,
    parameter int POUR_CYC    = 12,
    parameter int EJECT_CYC   = 4,
    parameter int CUP_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cmd,
`ifdef MDC_CUP_SENSE_EN
    input  logic       cup_ok,
`endif
    output logic       heater,
    output logic       valve_agua,
    output logic       valve_cafe,
    output logic       valve_te,
    output logic       eject_moneda,
    output logic       eject_cinco,
    output logic       err_led,
    output logic       busy,
    output logic       done
);

    localparam int c_max_cyc = mdc_max(mdc_max(HEAT_CYC, POUR_CYC), mdc_max(EJECT_CYC, CUP_TIMEOUT));
    localparam int c_cnt_w   = $clog2(c_max_cyc) + 1;

    localparam logic [c_cnt_w-1:0] c_heat_ld  = c_cnt_w'(HEAT_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_pour_ld  = c_cnt_w'(POUR_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_eject_ld = c_cnt_w'(EJECT_CYC - 1);
`ifdef MDC_CUP_SENSE_EN
    localparam logic [c_cnt_w-1:0] c_cup_ld   = c_cnt_w'(CUP_TIMEOUT - 1);
`endif

    logic [c_st_w-1:0]  r_state;
    logic               r_armed;
    logic               r_is_te;     // product latched at accept
    logic               r_cinco;     // which ejector the EJECT phase drives
    logic [c_st_w-1:0]  w_next;
    logic               w_accept;
    logic               w_is_te_n;
    logic               w_cinco_n;
    logic               w_load;
    logic [c_cnt_w-1:0] w_value;
    logic               w_en;
    logic               w_zero;
`ifdef MDC_CUP_SENSE_EN
    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w-1:0] r_pour_left; // reload value when pouring resumes
`endif

    mdc_temporizador #(.WIDTH(c_cnt_w)) u_tmr (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .value (w_value),
        .en    (w_en),
`ifdef MDC_CUP_SENSE_EN
        .count (w_count),
`endif
        .zero  (w_zero)
    );

    // A command is taken only once per NONE; reserved code neither runs nor disarms
    assign w_accept = (r_state == c_st_idle) && r_armed &&
                      (cmd != c_cmd_none) && (cmd != c_cmd_rsvd);

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_value   = '0;
        w_en      = 1'b0;
        w_is_te_n = r_is_te;
        w_cinco_n = r_cinco;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_is_te_n = (cmd == c_cmd_te);
                    w_cinco_n = (cmd == c_cmd_cambio);
                    case (cmd)
                        c_cmd_cafe, c_cmd_te: begin
                            w_next  = c_st_heat;
                            w_load  = 1'b1;
                            w_value = c_heat_ld;
                        end
                        c_cmd_cambio, c_cmd_devolver: begin
                            w_next  = c_st_eject;
                            w_load  = 1'b1;
                            w_value = c_eject_ld;
                        end
                        default: w_next = c_st_fault;
                    endcase
                end
            end
            c_st_heat: begin
                if (w_zero) begin
                    w_load = 1'b1;
`ifdef MDC_CUP_SENSE_EN
                    w_next  = c_st_wait_cup;
                    w_value = c_cup_ld;
`else
                    w_next  = c_st_pour;
                    w_value = c_pour_ld;
`endif
                end else begin
                    w_en = 1'b1;
                end
            end
`ifdef MDC_CUP_SENSE_EN
            c_st_wait_cup: begin
                if (cup_ok) begin
                    w_next  = c_st_pour;
                    w_load  = 1'b1;
                    w_value = r_pour_left;
                end else if (w_zero) begin
                    // No cup arrived: refund the inserted coin
                    w_next    = c_st_eject;
                    w_load    = 1'b1;
                    w_value   = c_eject_ld;
                    w_cinco_n = 1'b0;
                end else begin
                    w_en = 1'b1;
                end
            end
`endif
            c_st_pour: begin
                if (w_zero) begin
                    w_next = c_st_done;
`ifdef MDC_CUP_SENSE_EN
                end else if (!cup_ok) begin
                    w_next  = c_st_wait_cup;
                    w_load  = 1'b1;
                    w_value = c_cup_ld;
`endif
                end else begin
                    w_en = 1'b1;
                end
            end
            c_st_eject: begin
                if (w_zero) begin
                    w_next = c_st_done;
                end else begin
                    w_en = 1'b1;
                end
            end
            c_st_fault: begin
                if (cmd == c_cmd_none) begin
                    w_next = c_st_idle;
                end
            end
            default: w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= c_st_idle;
            r_armed      <= 1'b0;
            r_is_te      <= 1'b0;
            r_cinco      <= 1'b0;
            heater       <= 1'b0;
            valve_agua   <= 1'b0;
            valve_cafe   <= 1'b0;
            valve_te     <= 1'b0;
            eject_moneda <= 1'b0;
            eject_cinco  <= 1'b0;
            err_led      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef MDC_CUP_SENSE_EN
            r_pour_left  <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_is_te <= w_is_te_n;
            r_cinco <= w_cinco_n;
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (((r_state == c_st_idle) || (r_state == c_st_fault)) &&
                         (cmd == c_cmd_none)) begin
                r_armed <= 1'b1;
            end
`ifdef MDC_CUP_SENSE_EN
            if ((r_state == c_st_heat) && w_zero) begin
                r_pour_left <= c_pour_ld;
            end else if ((r_state == c_st_pour) && !w_zero && !cup_ok) begin
                // The cycle just finished was poured; keep what is left
                r_pour_left <= w_count - 1'b1;
            end
`endif
            // Outputs follow the state being entered so they are registered
            heater       <= (w_next == c_st_heat) || (w_next == c_st_pour) ||
                            (w_next == c_st_wait_cup);
            valve_agua   <= (w_next == c_st_pour);
            valve_cafe   <= (w_next == c_st_pour) && !w_is_te_n;
            valve_te     <= (w_next == c_st_pour) && w_is_te_n;
            eject_moneda <= (w_next == c_st_eject) && !w_cinco_n;
            eject_cinco  <= (w_next == c_st_eject) && w_cinco_n;
            err_led      <= (w_next == c_st_fault);
            busy         <= (w_next == c_st_heat) || (w_next == c_st_pour) ||
                            (w_next == c_st_wait_cup) || (w_next == c_st_eject) ||
                            (w_next == c_st_fault);
            done         <= (w_next == c_st_done);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdc_dispensador.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdc_dispensador
// Purpose  : Self-checking bench for mdc_dispensador. Expected output words
//            are queued as stimulus is driven and compared each cycle.
// Options  : MDC_CUP_SENSE_EN adds the cup-sense sequences
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdc_dispensador;
    import mdc_pkg::*;

    localparam int HEAT  = 8;
    localparam int POUR  = 12;
    localparam int EJECT = 4;
    localparam int CUPT  = 32;

    // Output word: {heater,agua,cafe,te,moneda,cinco,err,busy,done}
    localparam logic [8:0] c_w_idle = 9'b000000000;
    localparam logic [8:0] c_w_heat = 9'b100000010;
    localparam logic [8:0] c_w_cafe = 9'b111000010;
    localparam logic [8:0] c_w_te   = 9'b110100010;
    localparam logic [8:0] c_w_mon  = 9'b000010010;
    localparam logic [8:0] c_w_cin  = 9'b000001010;
    localparam logic [8:0] c_w_err  = 9'b000000110;
    localparam logic [8:0] c_w_done = 9'b000000001;

    localparam int K_IGN = 0, K_CAFE = 1, K_TE = 2, K_MON = 3, K_CIN = 4, K_FAULT = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] cmd = 3'b000;
`ifdef MDC_CUP_SENSE_EN
    logic       cup_ok = 1'b1;
`endif
    logic heater, valve_agua, valve_cafe, valve_te;
    logic eject_moneda, eject_cinco, err_led, busy, done;

    int          total = 0;
    int          bad   = 0;
    logic [8:0]  q[$];
    string       cur_tag = "reset";

    mdc_dispensador #(
        .HEAT_CYC(HEAT), .POUR_CYC(POUR), .EJECT_CYC(EJECT), .CUP_TIMEOUT(CUPT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd),
`ifdef MDC_CUP_SENSE_EN
        .cup_ok       (cup_ok),
`endif
        .heater       (heater),
        .valve_agua   (valve_agua),
        .valve_cafe   (valve_cafe),
        .valve_te     (valve_te),
        .eject_moneda (eject_moneda),
        .eject_cinco  (eject_cinco),
        .err_led      (err_led),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    wire [8:0] w_obs = {heater, valve_agua, valve_cafe, valve_te,
                        eject_moneda, eject_cinco, err_led, busy, done};

    // Exclusive actuator pairs, every cycle out of reset
    always @(negedge clk) begin
        if (rst) begin
            total++;
            if (!mdc_excl_ok(valve_cafe, valve_te) || !mdc_excl_ok(eject_moneda, eject_cinco)) begin
                bad++;
                $display("FAIL excl: cafe=%b te=%b moneda=%b cinco=%b, required no pair both on",
                         valve_cafe, valve_te, eject_moneda, eject_cinco);
            end
        end
    end

    task automatic push(input logic [8:0] w, input int n);
        repeat (n) q.push_back(w);
    endtask

    task automatic push_drink(input logic te);
        push(c_w_heat, HEAT);
`ifdef MDC_CUP_SENSE_EN
        push(c_w_heat, 1);   // one WAIT_CUP cycle with the cup already present
`endif
        push(te ? c_w_te : c_w_cafe, POUR);
        push(c_w_done, 1);
    endtask

    task automatic push_eject(input logic cinco);
        push(cinco ? c_w_cin : c_w_mon, EJECT);
        push(c_w_done, 1);
    endtask

    // Drive one cycle, then compare against the oldest expected word
    task automatic step(input logic [2:0] c);
        logic [8:0] e;
        cmd = c;
        @(posedge clk);
        #1;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, got %b", cur_tag, w_obs);
        end else begin
            e = q.pop_front();
            if (w_obs !== e) begin
                bad++;
                $display("FAIL %s: got %b required %b", cur_tag, w_obs, e);
            end
        end
    endtask

    task automatic drain(input logic [2:0] c);
        while (q.size() > 0) step(c);
    endtask

    typedef struct {
        logic       arm;
        logic [2:0] c;
        int         kind;
        int         extra;
        string      tag;
    } vec_t;

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1'b1, c_cmd_cafe,     K_CAFE,  3, "cafe"};
        tbl[1]  = '{1'b1, c_cmd_devolver, K_MON,   2, "devolver"};
        tbl[2]  = '{1'b0, c_cmd_cambio,   K_IGN,   3, "change_no_none"};
        tbl[3]  = '{1'b1, c_cmd_cambio,   K_CIN,   2, "cambio"};
        tbl[4]  = '{1'b1, c_cmd_te,       K_TE,    2, "te"};
        tbl[5]  = '{1'b1, c_cmd_rsvd,     K_IGN,   3, "reserved"};
        tbl[6]  = '{1'b0, c_cmd_devolver, K_MON,   1, "after_reserved"};
        tbl[7]  = '{1'b1, c_cmd_err_agua, K_FAULT, 5, "err_agua"};
        tbl[8]  = '{1'b0, c_cmd_cafe,     K_CAFE,  1, "after_fault"};
        tbl[9]  = '{1'b1, c_cmd_err_cafe, K_FAULT, 3, "err_cafe"};
        tbl[10] = '{1'b0, c_cmd_te,       K_TE,    2, "te_after_fault"};

        // Reset held with a command present, then released: not armed
        push(c_w_idle, 2);
        drain(c_cmd_cafe);
        rst = 1'b1;
        cur_tag = "no_arm_after_reset";
        push(c_w_idle, 4);
        drain(c_cmd_cafe);

        for (int i = 0; i < 11; i++) begin
            cur_tag = tbl[i].tag;
            if (tbl[i].arm) begin
                push(c_w_idle, 1);
                step(c_cmd_none);
            end
            case (tbl[i].kind)
                K_CAFE:  push_drink(1'b0);
                K_TE:    push_drink(1'b1);
                K_MON:   push_eject(1'b0);
                K_CIN:   push_eject(1'b1);
                K_FAULT: push(c_w_err, tbl[i].extra);
                default: ;
            endcase
            if (tbl[i].kind != K_FAULT) push(c_w_idle, tbl[i].extra);
            drain(tbl[i].c);
            if (tbl[i].kind == K_FAULT) begin
                // Leaving FAULT: lamp off on that edge and no done pulse
                push(c_w_idle, 1);
                step(c_cmd_none);
            end
        end

        // Command changes while busy are ignored, and do not re-arm
        cur_tag = "cmd_change_busy";
        push(c_w_idle, 1);
        step(c_cmd_none);
        push_eject(1'b1);
        step(c_cmd_cambio);
        drain(c_cmd_cafe);
        push(c_w_idle, 3);
        drain(c_cmd_cafe);

        // Reset in the middle of the pour
        cur_tag = "mid_reset";
        push(c_w_idle, 1);
        step(c_cmd_none);
        push(c_w_heat, HEAT);
`ifdef MDC_CUP_SENSE_EN
        push(c_w_heat, 1);
`endif
        push(c_w_cafe, 4);
        drain(c_cmd_cafe);
        rst = 1'b0;
        push(c_w_idle, 1);
        step(c_cmd_cafe);
        rst = 1'b1;
        push(c_w_idle, 3);
        drain(c_cmd_cafe);

`ifdef MDC_CUP_SENSE_EN
        // No cup ever: heat, full timeout, then refund
        cur_tag = "cup_timeout";
        cup_ok = 1'b0;
        push(c_w_idle, 1);
        step(c_cmd_none);
        push(c_w_heat, HEAT + CUPT);
        push_eject(1'b0);
        push(c_w_idle, 2);
        drain(c_cmd_cafe);

        // Cup arrives in wait cycle 3, leaves for 2 cycles mid-pour
        cur_tag = "cup_late";
        push(c_w_idle, 1);
        step(c_cmd_none);
        push(c_w_heat, HEAT + 3);
        drain(c_cmd_te);
        cup_ok = 1'b1;
        push(c_w_te, 5);
        drain(c_cmd_te);
        cup_ok = 1'b0;
        push(c_w_heat, 2);
        drain(c_cmd_te);
        cup_ok = 1'b1;
        push(c_w_te, POUR - 5);
        push(c_w_done, 1);
        push(c_w_idle, 2);
        drain(c_cmd_te);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
